// File: rtl/vga_pkg.sv
// Shared phase encoding, default 640x480@60 timing and counter sizing helper
// for the VGA timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    SYNC        = 2'd0,
    BACK_PORCH  = 2'd1,
    DISPLAY     = 2'd2,
    FRONT_PORCH = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Bits needed to count 0..longest_phase-1 (never less than one bit).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: SYNC -> BACK_PORCH -> DISPLAY -> FRONT_PORCH phase walker
// with an in-phase counter; wrap flags the last unit of FRONT_PORCH.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int LEN_SYNC = 1,
  parameter int LEN_BP   = 1,
  parameter int LEN_DISP = 1,
  parameter int LEN_FP   = 1,
  parameter int CW       = cnt_width(LEN_SYNC, LEN_BP, LEN_DISP, LEN_FP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output phase_t        state,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] last;

  always_comb begin
    last = CW'(LEN_SYNC - 1);
    case (state)
      SYNC:        last = CW'(LEN_SYNC - 1);
      BACK_PORCH:  last = CW'(LEN_BP - 1);
      DISPLAY:     last = CW'(LEN_DISP - 1);
      FRONT_PORCH: last = CW'(LEN_FP - 1);
      default:     last = CW'(LEN_SYNC - 1);
    endcase
  end

  assign wrap = adv && (state == FRONT_PORCH) && (cnt == last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
      cnt   <= '0;
    end else if (adv) begin
      if (cnt == last) begin
        cnt <= '0;
        case (state)
          SYNC:        state <= BACK_PORCH;
          BACK_PORCH:  state <= DISPLAY;
          DISPLAY:     state <= FRONT_PORCH;
          FRONT_PORCH: state <= SYNC;
          default:     state <= SYNC;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-enable driven VGA timing: sync/de/coordinates one pixel behind the
// internal position, plus a prefetch coordinate stream leading by PREFETCH.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PREFETCH  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pix_ce,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output phase_t                      h_state,
  output phase_t                      v_state,
  output logic                        line_start,
  output logic                        frame_start,
  output logic                        fetch_valid,
  output logic [$clog2(H_ACTIVE)-1:0] fetch_x,
  output logic [$clog2(V_ACTIVE)-1:0] fetch_y
);

  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int PW      = $clog2(H_TOTAL);
  localparam int HCW     = cnt_width(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int VCW     = cnt_width(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int FSTART  = H_SYNC + H_BP - PREFETCH;

  localparam logic [PW-1:0] H_LAST_P = PW'(H_TOTAL - 1);
  localparam logic [PW-1:0] FSTART_P = PW'(FSTART);
  localparam logic [PW-1:0] FEND_P   = PW'(FSTART + H_ACTIVE);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_len
    $error("vga_timing_gen: every phase length must be non-zero");
  end
  if (PREFETCH < 0 || PREFETCH > H_SYNC + H_BP - 1) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH must lie in 0 .. H_SYNC+H_BP-1");
  end

  phase_t           h_st, v_st;
  logic [HCW-1:0]   h_cnt;
  logic [VCW-1:0]   v_cnt;
  logic             h_wrap, v_wrap;
  logic [PW-1:0]    h_pos;
  logic             frame_head;
  logic             h_disp, v_disp, in_fetch;

  vga_axis_counter #(
    .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .LEN_DISP(H_ACTIVE), .LEN_FP(H_FP), .CW(HCW)
  ) u_h (
    .clk(clk), .reset(reset), .adv(pix_ce),
    .state(h_st), .cnt(h_cnt), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .LEN_DISP(V_ACTIVE), .LEN_FP(V_FP), .CW(VCW)
  ) u_v (
    .clk(clk), .reset(reset), .adv(h_wrap),
    .state(v_st), .cnt(v_cnt), .wrap(v_wrap)
  );

  assign h_disp   = (h_st == DISPLAY);
  assign v_disp   = (v_st == DISPLAY);
  assign in_fetch = v_disp && (h_pos >= FSTART_P) && (h_pos < FEND_P);

  // Internal position: h_pos mirrors the horizontal phase counters as a flat
  // column index; frame_head marks position 0 (after reset or the last pixel).
  always_ff @(posedge clk) begin
    if (reset) begin
      h_pos      <= '0;
      frame_head <= 1'b1;
    end else if (pix_ce) begin
      h_pos      <= (h_pos == H_LAST_P) ? '0 : h_pos + 1'b1;
      frame_head <= v_wrap;
    end
  end

  // Output stage: registered view of the position held at this pixel enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      h_state     <= SYNC;
      v_state     <= SYNC;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else begin
      line_start  <= pix_ce && (h_pos == '0);
      frame_start <= pix_ce && frame_head;
      if (pix_ce) begin
        hsync       <= (h_st == SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= (v_st == SYNC) ? VSYNC_POL : ~VSYNC_POL;
        de          <= h_disp && v_disp;
        h_state     <= h_st;
        v_state     <= v_st;
        fetch_valid <= in_fetch;
        if (h_disp && v_disp) begin
          x <= XW'(h_cnt);
          y <= YW'(v_cnt);
        end
        if (in_fetch) begin
          fetch_x <= XW'(h_pos - FSTART_P);
          fetch_y <= YW'(v_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a 15x8 mode: vector table, timing sequences and
// random pix_ce/reset against a position-arithmetic reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HT = 15;
  localparam int FT = 120;

  typedef struct packed {
    logic       hsync, vsync, de;
    logic [2:0] x;
    logic [1:0] y;
    logic [1:0] hs, vs;
    logic       ls, fs, fv;
    logic [2:0] fx;
    logic [1:0] fy;
  } out_t;

  typedef struct {
    logic r, ce;
    logic hsync, vsync, de, ls, fs;
    logic [1:0] hs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b0;

  logic a_hsync, a_vsync, a_de, a_ls, a_fs, a_fv;
  logic [2:0] a_x, a_fx;
  logic [1:0] a_y, a_fy;
  phase_t a_hs, a_vs;
  logic b_hsync, b_vsync, b_de, b_ls, b_fs, b_fv;
  logic [2:0] b_x, b_fx;
  logic [1:0] b_y, b_fy;
  phase_t b_hs, b_vs;

  out_t outA, outB, expA, expB;
  int checks = 0;
  int errors = 0;
  int cec = 0;
  logic ce_tog = 1'b1;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH(2)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .x(a_x), .y(a_y),
    .h_state(a_hs), .v_state(a_vs), .line_start(a_ls), .frame_start(a_fs),
    .fetch_valid(a_fv), .fetch_x(a_fx), .fetch_y(a_fy)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PREFETCH(0)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .x(b_x), .y(b_y),
    .h_state(b_hs), .v_state(b_vs), .line_start(b_ls), .frame_start(b_fs),
    .fetch_valid(b_fv), .fetch_x(b_fx), .fetch_y(b_fy)
  );

  assign outA = {a_hsync, a_vsync, a_de, a_x, a_y, a_hs, a_vs, a_ls, a_fs, a_fv, a_fx, a_fy};
  assign outB = {b_hsync, b_vsync, b_de, b_x, b_y, b_hs, b_vs, b_ls, b_fs, b_fv, b_fx, b_fy};

  function automatic out_t rst_out(input bit hp, input bit vp);
    out_t o;
    o = '0;
    o.hsync = ~hp;
    o.vsync = ~vp;
    return o;
  endfunction

  // Expected outputs for frame position idx, derived from phase lengths.
  function automatic out_t pos_out(input int pf, input bit hp, input bit vp,
                                   input int idx, input out_t prev);
    out_t o;
    int h, l, hph, vph, fst;
    o = prev;
    h = idx % HT;
    l = idx / HT;
    hph = (h < 3) ? 0 : (h < 5) ? 1 : (h < 13) ? 2 : 3;
    vph = (l < 2) ? 0 : (l < 3) ? 1 : (l < 7) ? 2 : 3;
    fst = 5 - pf;
    o.hsync = (hph == 0) ? hp : ~hp;
    o.vsync = (vph == 0) ? vp : ~vp;
    o.de = (hph == 2) && (vph == 2);
    if (o.de) begin
      o.x = 3'(h - 5);
      o.y = 2'(l - 3);
    end
    o.hs = 2'(hph);
    o.vs = 2'(vph);
    o.ls = (h == 0);
    o.fs = (idx == 0);
    o.fv = (vph == 2) && (h >= fst) && (h < fst + 8);
    if (o.fv) begin
      o.fx = 3'(h - fst);
      o.fy = 2'(l - 3);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic c);
    reset = r;
    pix_ce = c;
    @(posedge clk);
    if (r) begin
      expA = rst_out(1'b0, 1'b0);
      expB = rst_out(1'b1, 1'b1);
      cec = 0;
    end else if (c) begin
      expA = pos_out(2, 1'b0, 1'b0, cec % FT, expA);
      expB = pos_out(0, 1'b1, 1'b1, cec % FT, expB);
      cec++;
    end else begin
      expA.ls = 1'b0; expA.fs = 1'b0;
      expB.ls = 1'b0; expB.fs = 1'b0;
    end
    #1;
    chk("model_a", 64'(outA), 64'(expA));
    chk("model_b", 64'(outB), 64'(expB));
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return a_fs;
      1: return a_ls;
      2: return a_de;
      default: return a_fv;
    endcase
  endfunction

  task automatic run_until(input int sel, input bit alt, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step(1'b0, alt ? ce_tog : 1'b1);
      if (alt) ce_tog = ~ce_tog;
      if (sig(sel)) begin
        n = k;
        break;
      end
    end
  endtask

  vec_t tbl[10];
  int n, de_cnt, hl_cnt, vl_cnt, bh_cnt;
  logic [2:0] last_x;
  logic [1:0] last_y;

  initial begin
    expA = '0;
    expB = '0;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};

    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].ce);
      chk($sformatf("vec%0d", i),
          64'({a_hsync, a_vsync, a_de, a_ls, a_fs, a_hs}),
          64'({tbl[i].hsync, tbl[i].vsync, tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].hs}));
    end

    // Frame/line periods and first active pixel with continuous pix_ce.
    step(1'b1, 1'b1);
    run_until(0, 1'b0, 10, n);   chk("first_fs", 64'(n), 64'd1);
    run_until(1, 1'b0, 40, n);   chk("line_period", 64'(n), 64'd15);
    run_until(3, 1'b0, 200, n);  chk("fv_offset", 64'(n), 64'd33);
    run_until(2, 1'b0, 20, n);   chk("fv_lead", 64'(n), 64'd2);
    chk("first_de_xy", 64'({a_x, a_y, a_fx}), 64'({3'd0, 2'd0, 3'd2}));
    run_until(0, 1'b0, 200, n);  chk("fs_after_de", 64'(n), 64'd70);

    // Per-frame pulse counts, starting at the frame_start sample.
    de_cnt = 0; hl_cnt = 0; vl_cnt = 0; bh_cnt = 0;
    last_x = '0; last_y = '0;
    for (int k = 0; k < FT; k++) begin
      if (k > 0) step(1'b0, 1'b1);
      if (a_de) begin
        de_cnt++;
        last_x = a_x;
        last_y = a_y;
      end
      if (!a_hsync) hl_cnt++;
      if (!a_vsync) vl_cnt++;
      if (b_hsync) bh_cnt++;
    end
    chk("de_per_frame", 64'(de_cnt), 64'd32);
    chk("hsync_low", 64'(hl_cnt), 64'd24);
    chk("vsync_low", 64'(vl_cnt), 64'd30);
    chk("hsync_high_pol1", 64'(bh_cnt), 64'd24);
    chk("last_de_xy", 64'({last_x, last_y}), 64'({3'd7, 2'd3}));
    run_until(0, 1'b0, 10, n);   chk("frame_period", 64'(n), 64'd1);

    // Alternating pix_ce doubles every period.
    ce_tog = 1'b0;
    run_until(0, 1'b1, 500, n);  chk("fs_align_alt", 64'(n > 0), 64'd1);
    run_until(1, 1'b1, 100, n);  chk("line_period_alt", 64'(n), 64'd30);
    run_until(0, 1'b1, 500, n);  chk("frame_period_alt", 64'(n), 64'd210);
    run_until(0, 1'b1, 500, n);  chk("frame_period_alt2", 64'(n), 64'd240);

    // Reset 57 clocks after a frame start.
    run_until(0, 1'b0, 300, n);  chk("fs_before_rst", 64'(n > 0), 64'd1);
    for (int k = 1; k < 57; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("rst_outputs", 64'({a_hsync, a_vsync, a_de, a_fs, a_fv}), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    step(1'b0, 1'b1);
    chk("post_rst_fs", 64'({a_fs, a_ls, a_hsync, a_vsync, a_hs, a_vs}),
        64'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}));

    // Random pix_ce with rare resets.
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
